// File: rtl/main_memory_defs_pkg.sv
// Shared definitions for the main_memory capture path: default widths matching
// main_memory_bram, capture FSM state encoding and the post-count clamp helper.
package main_memory_defs_pkg;

    localparam int unsigned BRAM_DATA_WIDTH_DEF = 16;
    localparam int unsigned BRAM_ADDR_WIDTH_DEF = 15;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StCapture = 2'd2,
        StDone    = 2'd3
    } cap_state_t;

    // Post count of 0 means "just the trigger sample"; more than the ring depth
    // is pointless, so cap it at exactly one full ring.
    function automatic int unsigned clamp_post(input int unsigned cnt, input int unsigned aw);
        int unsigned depth;
        depth = 32'd1 << aw;
        if (cnt == 0) begin
            return 1;
        end else if (cnt > depth) begin
            return depth;
        end else begin
            return cnt;
        end
    endfunction

endpackage

// File: rtl/main_memory_wrap_counter.sv
// Ring write pointer: AW-bit up counter with synchronous clear (priority over
// enable) and a combinational wrap pulse for the max -> 0 step.
module main_memory_wrap_counter #(
    parameter int unsigned AW = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [AW-1:0] count,
    output logic          wrap
);

    localparam logic [AW-1:0] One = AW'(1);

    logic [AW-1:0] count_q;

    // Pointer register; clear wins over increment.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + One;
        end
    end

    // Wrap fires in the cycle the increment takes the pointer from max to 0.
    always_comb begin
        wrap = en && !clr && (count_q == '1);
    end

    assign count = count_q;

endmodule

// File: rtl/main_memory_capture_ctrl.sv
// Write-side capture controller ahead of main_memory_bram: circular pre-trigger
// history while armed, programmed number of post-trigger samples, then stop.
module main_memory_capture_ctrl
    import main_memory_defs_pkg::*;
#(
    parameter int unsigned BRAM_DATA_WIDTH = BRAM_DATA_WIDTH_DEF,
    parameter int unsigned BRAM_ADDR_WIDTH = BRAM_ADDR_WIDTH_DEF
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_arm,
    input  logic                       i_abort,
    input  logic                       i_trig,
    input  logic [BRAM_ADDR_WIDTH:0]   i_post_count,
    input  logic [BRAM_DATA_WIDTH-1:0] i_sample_data,
    input  logic                       i_sample_valid,
    output logic [BRAM_ADDR_WIDTH-1:0] o_bram_wr_addr,
    output logic [BRAM_DATA_WIDTH-1:0] o_bram_wr_data,
    output logic                       o_bram_wr_en,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [BRAM_ADDR_WIDTH-1:0] o_trig_addr,
    output logic [BRAM_ADDR_WIDTH-1:0] o_start_addr
);

    localparam int unsigned AW = BRAM_ADDR_WIDTH;
    localparam int unsigned DW = BRAM_DATA_WIDTH;
    localparam logic [AW-1:0] PtrOne = AW'(1);
    localparam logic [AW:0]   CntOne = (AW + 1)'(1);

    cap_state_t state_q, state_d;

    logic [AW:0]   post_q, post_d;    // clamped count latched at arm
    logic [AW:0]   cnt_q, cnt_d;      // post samples still to write
    logic          wrapped_q, wrapped_d;

    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic          wr_en_q, wr_en_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [AW-1:0] trig_addr_q, trig_addr_d;
    logic [AW-1:0] start_addr_q, start_addr_d;

    logic          ptr_clr, ptr_en, ptr_wrap;
    logic [AW-1:0] ptr;

    main_memory_wrap_counter #(
        .AW(AW)
    ) u_wr_ptr (
        .clk  (i_clk),
        .rst  (i_rst),
        .clr  (ptr_clr),
        .en   (ptr_en),
        .count(ptr),
        .wrap (ptr_wrap)
    );

    // Next-state, post counter and registered write-port values.
    always_comb begin
        state_d      = state_q;
        post_d       = post_q;
        cnt_d        = cnt_q;
        wrapped_d    = wrapped_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        wr_en_d      = 1'b0;
        done_d       = done_q;
        trig_addr_d  = trig_addr_q;
        start_addr_d = start_addr_q;
        ptr_clr      = 1'b0;
        ptr_en       = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                // Abort is meaningless here, so a coincident arm simply wins.
                if (i_arm) begin
                    state_d      = StArmed;
                    done_d       = 1'b0;
                    trig_addr_d  = '0;
                    start_addr_d = '0;
                    wrapped_d    = 1'b0;
                    ptr_clr      = 1'b1;
                    post_d       = (AW + 1)'(clamp_post(32'(i_post_count), AW));
                end
            end
            StArmed, StCapture: begin
                if (i_abort) begin
                    state_d = StIdle;
                end else if (i_sample_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ptr;
                    wr_data_d = i_sample_data;
                    ptr_en    = 1'b1;
                    if (ptr_wrap) begin
                        wrapped_d = 1'b1;
                    end
                    if (state_q == StArmed) begin
                        if (i_trig) begin
                            trig_addr_d = ptr;
                            cnt_d       = post_q - CntOne;
                            state_d     = (post_q == CntOne) ? StDone : StCapture;
                        end
                    end else begin
                        cnt_d   = cnt_q - CntOne;
                        state_d = (cnt_q == CntOne) ? StDone : StCapture;
                    end
                    if (state_d == StDone) begin
                        done_d       = 1'b1;
                        start_addr_d = (wrapped_q || ptr_wrap) ? (ptr + PtrOne) : '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StArmed) || (state_d == StCapture);
    end

    // State and output register stage.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= StIdle;
            post_q       <= '0;
            cnt_q        <= '0;
            wrapped_q    <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            trig_addr_q  <= '0;
            start_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            post_q       <= post_d;
            cnt_q        <= cnt_d;
            wrapped_q    <= wrapped_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_en_q      <= wr_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            trig_addr_q  <= trig_addr_d;
            start_addr_q <= start_addr_d;
        end
    end

    assign o_bram_wr_addr = wr_addr_q;
    assign o_bram_wr_data = wr_data_q;
    assign o_bram_wr_en   = wr_en_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign o_trig_addr    = trig_addr_q;
    assign o_start_addr   = start_addr_q;

endmodule

// File: tb/tb_main_memory_capture_ctrl.sv
// Scoreboard bench for main_memory_capture_ctrl with a 16-entry ring.
module tb_main_memory_capture_ctrl;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 16;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_arm = 1'b0;
    logic          i_abort = 1'b0;
    logic          i_trig = 1'b0;
    logic [AW:0]   i_post_count = '0;
    logic [DW-1:0] i_sample_data = '0;
    logic          i_sample_valid = 1'b0;
    logic [AW-1:0] o_bram_wr_addr;
    logic [DW-1:0] o_bram_wr_data;
    logic          o_bram_wr_en;
    logic          o_busy;
    logic          o_done;
    logic [AW-1:0] o_trig_addr;
    logic [AW-1:0] o_start_addr;

    main_memory_capture_ctrl #(
        .BRAM_DATA_WIDTH(DW),
        .BRAM_ADDR_WIDTH(AW)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_arm         (i_arm),
        .i_abort       (i_abort),
        .i_trig        (i_trig),
        .i_post_count  (i_post_count),
        .i_sample_data (i_sample_data),
        .i_sample_valid(i_sample_valid),
        .o_bram_wr_addr(o_bram_wr_addr),
        .o_bram_wr_data(o_bram_wr_data),
        .o_bram_wr_en  (o_bram_wr_en),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_trig_addr   (o_trig_addr),
        .o_start_addr  (o_start_addr)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          done;
    } exp_t;

    exp_t          sb[$];
    int            total = 0;
    int            bad = 0;
    logic [DW-1:0] dat = 16'h0100;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every write on the port must match the head of the scoreboard.
    always @(negedge i_clk) begin
        if (o_bram_wr_en) begin
            if (sb.size() == 0) begin
                chk("unexpected write", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wr_addr", int'(o_bram_wr_addr), int'(e.addr));
                chk("wr_data", int'(o_bram_wr_data), int'(e.data));
                chk("done_at_write", int'(o_done), int'(e.done));
            end
        end
    end

    // One clock of stimulus; outputs are settled when this returns.
    task automatic cyc(input logic arm, input logic abort, input logic valid,
                       input logic trig, input logic [AW:0] post);
        i_arm          = arm;
        i_abort        = abort;
        i_sample_valid = valid;
        i_trig         = trig;
        i_post_count   = post;
        i_sample_data  = dat;
        @(posedge i_clk);
        #1;
        if (valid) dat = dat + 16'd1;
        i_arm          = 1'b0;
        i_abort        = 1'b0;
        i_sample_valid = 1'b0;
        i_trig         = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic arm(input logic [AW:0] post);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, post);
    endtask

    // Valid sample that must be written at addr a.
    task automatic samp(input logic trig, input int a, input logic last);
        exp_t e;
        e.addr = AW'(a);
        e.data = dat;
        e.done = last;
        sb.push_back(e);
        cyc(1'b0, 1'b0, 1'b1, trig, '0);
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        idle(1);
        while (sb.size() != 0 && n < 20) begin
            idle(1);
            n++;
        end
        chk(nm, sb.size(), 0);
    endtask

    initial begin
        // 1: reset, then unarmed samples produce no writes
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        chk("rst busy", int'(o_busy), 0);
        chk("rst done", int'(o_done), 0);
        chk("rst wr_en", int'(o_bram_wr_en), 0);
        chk("rst trig_addr", int'(o_trig_addr), 0);
        chk("rst start_addr", int'(o_start_addr), 0);
        chk("rst wr_addr", int'(o_bram_wr_addr), 0);
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, '0);
        idle(1);
        chk("t1 busy", int'(o_busy), 0);
        chk("t1 done", int'(o_done), 0);

        // 2: post=4, trigger on 6th sample at addr 5
        dat = 16'h0100;
        arm(5'd4);
        chk("t2 busy armed", int'(o_busy), 1);
        for (int i = 0; i < 5; i++) samp(1'b0, i, 1'b0);
        samp(1'b1, 5, 1'b0);
        chk("t2 busy capture", int'(o_busy), 1);
        samp(1'b0, 6, 1'b0);
        samp(1'b0, 7, 1'b0);
        samp(1'b0, 8, 1'b1);
        chk("t2 done", int'(o_done), 1);
        chk("t2 busy", int'(o_busy), 0);
        chk("t2 trig_addr", int'(o_trig_addr), 5);
        chk("t2 start_addr", int'(o_start_addr), 0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, '0);
        drain("t2 drain");

        // 3: post=8 after 30 pre-trigger samples, ring wraps
        arm(5'd8);
        chk("t3 done cleared", int'(o_done), 0);
        chk("t3 trig cleared", int'(o_trig_addr), 0);
        for (int i = 0; i < 30; i++) samp(1'b0, i % 16, 1'b0);
        samp(1'b1, 14, 1'b0);
        samp(1'b0, 15, 1'b0);
        for (int i = 0; i < 6; i++) samp(1'b0, i, i == 5);
        chk("t3 done", int'(o_done), 1);
        chk("t3 trig_addr", int'(o_trig_addr), 14);
        chk("t3 start_addr", int'(o_start_addr), 6);
        drain("t3 drain");

        // 4a: post=0 clamps to 1
        arm(5'd0);
        samp(1'b1, 0, 1'b1);
        chk("t4 done", int'(o_done), 1);
        chk("t4 busy", int'(o_busy), 0);
        chk("t4 trig_addr", int'(o_trig_addr), 0);
        chk("t4 start_addr", int'(o_start_addr), 0);
        // 4b: gaps in CAPTURE do not consume post samples
        arm(5'd3);
        samp(1'b1, 0, 1'b0);
        idle(3);
        chk("t4 gap done", int'(o_done), 0);
        chk("t4 gap busy", int'(o_busy), 1);
        samp(1'b0, 1, 1'b0);
        idle(3);
        samp(1'b0, 2, 1'b1);
        chk("t4 gap end done", int'(o_done), 1);
        drain("t4 drain");

        // 5: abort with a valid sample in CAPTURE, then re-arm
        arm(5'd5);
        idle(2);
        samp(1'b1, 2'd0, 1'b0);
        samp(1'b0, 1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, '0);
        chk("t5 abort busy", int'(o_busy), 0);
        chk("t5 abort done", int'(o_done), 0);
        chk("t5 abort wr_en", int'(o_bram_wr_en), 0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, '0);
        arm(5'd2);
        samp(1'b1, 0, 1'b0);
        samp(1'b0, 1, 1'b1);
        chk("t5 rearm done", int'(o_done), 1);
        // arm+abort from DONE: arm wins
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 5'd2);
        chk("t5 arm+abort busy", int'(o_busy), 1);
        chk("t5 arm+abort done", int'(o_done), 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
        chk("t5 abort armed", int'(o_busy), 0);
        drain("t5 drain");

        // 6: reset mid-capture, then arm while ARMED is ignored
        arm(5'd6);
        samp(1'b1, 0, 1'b0);
        samp(1'b0, 1, 1'b0);
        i_rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, '0);
        chk("t6 rst wr_en", int'(o_bram_wr_en), 0);
        chk("t6 rst busy", int'(o_busy), 0);
        chk("t6 rst trig_addr", int'(o_trig_addr), 0);
        chk("t6 rst wr_addr", int'(o_bram_wr_addr), 0);
        chk("t6 rst wr_data", int'(o_bram_wr_data), 0);
        i_rst = 1'b0;
        arm(5'd8);
        for (int i = 0; i < 3; i++) samp(1'b0, i, 1'b0);
        arm(5'd2);
        samp(1'b0, 3, 1'b0);
        samp(1'b1, 4, 1'b0);
        for (int i = 5; i < 12; i++) samp(1'b0, i, i == 11);
        chk("t6 done", int'(o_done), 1);
        chk("t6 trig_addr", int'(o_trig_addr), 4);
        drain("t6 drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
